// File: rtl/det_event_logger_pkg.sv
// Shared constants and types for the det_event_logger slice.
package det_event_logger_pkg;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_TS_W  = 16;
  localparam int DEF_CNT_W = 8;

  typedef logic [DEF_TS_W-1:0] stamp_t;

  // Width of a FIFO pointer or level field: one extra bit beyond the index.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/det_event_logger_if.sv
// Event drain port: logger presents head event, host accepts it with ready.
interface det_event_logger_if
  import det_event_logger_pkg::*;
#(
  parameter int TS_W = DEF_TS_W
);
  logic            evt_valid;
  logic            evt_ready;
  logic [TS_W-1:0] evt_stamp;

  modport master (output evt_valid, output evt_stamp, input evt_ready);
  modport slave  (input evt_valid, input evt_stamp, output evt_ready);
endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO; head entry is always visible on dout_o.
module sync_fifo_fwft
  import det_event_logger_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int W     = DEF_TS_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [W-1:0]             dout_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, rd_q, wr_d, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push_s, do_pop_s;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level_o = wr_q - rd_q;
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  // Qualify requests; a full FIFO still accepts a push when the head leaves.
  always_comb begin
    do_pop_s  = pop_i & ~empty_o;
    do_push_s = push_i & (~full_o | do_pop_s);
    wr_d      = wr_q;
    rd_d      = rd_q;
    if (clr_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push_s) wr_d = wr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop_s)  rd_d = rd_q + {{AW{1'b0}}, 1'b1};
    end
  end

  // Pointer and storage registers; storage is cleared on reset too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (!clr_i && do_push_s) mem_q[wr_q[AW-1:0]] <= din_i;
    end
  end
endmodule

// File: rtl/det_event_logger.sv
// Timestamps each detector pulse and queues it for a host to drain.
module det_event_logger
  import det_event_logger_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int TS_W  = DEF_TS_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   det,
  input  logic                   clear,
  det_event_logger_if.master     evt,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]       total_count,
  output logic                   overflow
);
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             event_s, pop_s, drop_s, full_s, empty_s;

  sync_fifo_fwft #(.DEPTH(DEPTH), .W(TS_W)) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .clr_i   (clear),
    .push_i  (event_s),
    .pop_i   (pop_s),
    .din_i   (ts_q),
    .full_o  (full_s),
    .empty_o (empty_s),
    .level_o (fifo_level),
    .dout_o  (evt.evt_stamp)
  );

  assign evt.evt_valid = ~empty_s;
  assign total_count   = cnt_q;
  assign overflow      = ovf_q;

  // Event qualification, drop detection and next-state for counters/flag.
  always_comb begin
    event_s = det & ~clear;
    pop_s   = ~empty_s & evt.evt_ready & ~clear;
    drop_s  = event_s & full_s & ~pop_s;
    ts_d    = ts_q + {{(TS_W-1){1'b0}}, 1'b1};
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clear) begin
      ts_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (event_s && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_d = cnt_q;
      end
      if (drop_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
    end
  end

  // Timestamp counter, saturating event count and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ts_q  <= ts_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_det_event_logger.sv
// Randomized and directed bench for det_event_logger against a queue model.
module tb_det_event_logger;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset, det, clear, det2;
  logic [2:0] fifo_level, fifo_level2;
  logic [7:0] total_count, total_count2;
  logic       overflow, overflow2;

  int checks = 0;
  int errors = 0;

  // reference model state
  int ts_m;
  int cnt_m;
  bit ovf_m;
  int q_m[$];

  det_event_logger_if #(.TS_W(16)) bus ();
  det_event_logger_if #(.TS_W(4))  bus2 ();

  det_event_logger #(.DEPTH(4), .TS_W(16), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .det(det), .clear(clear), .evt(bus),
    .fifo_level(fifo_level), .total_count(total_count), .overflow(overflow)
  );

  det_event_logger #(.DEPTH(4), .TS_W(4), .CNT_W(8)) dut_w4 (
    .clk(clk), .reset(reset), .det(det2), .clear(1'b0), .evt(bus2),
    .fifo_level(fifo_level2), .total_count(total_count2), .overflow(overflow2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    ts_m = 0; cnt_m = 0; ovf_m = 1'b0; q_m.delete();
  endtask

  // one clock edge of the logger, computed from the behavioural rules
  task automatic model_edge(input bit d, input bit c, input bit r);
    if (c) begin
      model_reset();
    end else begin
      if (q_m.size() != 0 && r) void'(q_m.pop_front());
      if (d) begin
        if (q_m.size() < DEPTH) q_m.push_back(ts_m);
        else ovf_m = 1'b1;
        if (cnt_m < 255) cnt_m++;
      end
      ts_m = (ts_m + 1) % 65536;
    end
  endtask

  task automatic compare_all();
    check("evt_valid", bus.evt_valid, (q_m.size() != 0) ? 1 : 0);
    if (q_m.size() != 0) check("evt_stamp", bus.evt_stamp, q_m[0]);
    check("fifo_level", fifo_level, q_m.size());
    check("total_count", total_count, cnt_m);
    check("overflow", overflow, ovf_m);
  endtask

  // drive at negedge, model the posedge, compare at the next negedge
  task automatic step(input bit d, input bit c, input bit r);
    det = d; clear = c; bus.evt_ready = r;
    @(posedge clk);
    model_edge(d, c, r);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    reset = 1'b1; det = 1'b0; clear = 1'b0; det2 = 1'b0;
    bus.evt_ready = 1'b0; bus2.evt_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    reset = 1'b0;

    // single event at ts=5, ready high
    while (ts_m < 5) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check("t1_stamp5", bus.evt_stamp, 5);
    step(1'b0, 1'b0, 1'b1);
    check("t1_drained", bus.evt_valid, 0);

    // five pulses, host stalled: fills and overflows
    while (ts_m <= 22) step((ts_m >= 10) && ((ts_m - 10) % 3 == 0), 1'b0, 1'b0);
    check("t2_level4", fifo_level, 4);
    check("t2_ovf", overflow, 1);
    check("t2_count", total_count, 6);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
    check("t2_empty", bus.evt_valid, 0);

    // full FIFO with simultaneous push and pop
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check("t3_level", fifo_level, 4);
    check("t3_ovf", overflow, 0);

    // saturation of total_count
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 1'b1);
    check("t4_sat", total_count, 255);

    // clear with det while two entries held
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("t5_level2", fifo_level, 2);
    step(1'b1, 1'b1, 1'b0);
    check("t5_clr_level", fifo_level, 0);
    check("t5_clr_count", total_count, 0);
    step(1'b1, 1'b0, 1'b0);
    check("t5_ts0", bus.evt_stamp, 0);

    // random traffic
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 2) != 0, $urandom_range(0, 59) == 0, $urandom_range(0, 1) != 0);

    // async reset between edges, then 4-bit timestamp wrap on the second instance
    det = 1'b1; clear = 1'b0; bus.evt_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_valid", bus.evt_valid, 0);
    check("rst_stamp", bus.evt_stamp, 0);
    check("rst_level", fifo_level, 0);
    check("rst_count", total_count, 0);
    check("rst_ovf", overflow, 0);
    det = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 1'b0);
    det2 = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    det2 = 1'b0;
    check("w4_valid", bus2.evt_valid, 1);
    check("w4_stamp_wrap", bus2.evt_stamp, 1);
    check("w4_count", total_count2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
